// File: rtl/mc_decode_if.sv
// Instruction-field / control-bundle interface between the instruction register side
// (master) and the multicycle ARM-subset control unit (slave).
interface mc_decode_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 MulI;
  logic [1:0]           FlagW;
  logic                 PCS;
  logic                 NextPC;
  logic                 RegW;
  logic                 MemW;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           State;

  modport master (
    output Op, Funct, Rd, MulI,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    input  Op, Funct, Rd, MulI,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/mc_decode_unit.sv
// Multicycle ARM-subset control unit: sequencing FSM, ALU decoder, PC logic, instruction decoder.
// Optional multiply wait state enabled by defining MC_DECODE_MUL_EN.
module mc_decode_unit #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  mc_decode_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
`ifdef MC_DECODE_MUL_EN
    , MULWAIT = 4'd10
`endif
  } state_e;

  state_e     state_q, state_d, dec_state_s;
  logic [2:0] alu_code_s;
  logic       is_cmp_s, known_s, arith_s;
  logic       alu_op_s, branch_s, mul_s;
  logic       irwrite_s, nextpc_s, regw_s, memw_s, adrsrc_s;
  logic [1:0] resultsrc_s, alusrca_s, alusrcb_s, flagw_s;
  logic [2:0] aluctrl_s;

`ifdef MC_DECODE_MUL_EN
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;

  // Multiply wait counter register
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_muli_s;
  assign unused_muli_s = bus.MulI;
`endif

  // State register; low reset aborts any instruction back to FETCH
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // ALU command decode on Funct[4:1]
  always_comb begin
    alu_code_s = 3'd0;
    is_cmp_s   = 1'b0;
    known_s    = 1'b1;
    arith_s    = 1'b0;
    case (bus.Funct[4:1])
      4'b0100: begin alu_code_s = 3'd0; arith_s = 1'b1; end
      4'b0010: begin alu_code_s = 3'd1; arith_s = 1'b1; end
      4'b1010: begin alu_code_s = 3'd1; arith_s = 1'b1; is_cmp_s = 1'b1; end
      4'b0000: alu_code_s = 3'd2;
      4'b1100: alu_code_s = 3'd3;
      4'b0001: alu_code_s = 3'd4;
      4'b1101: alu_code_s = 3'd5;
      default: known_s = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef MC_DECODE_MUL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01: state_d = MEMADR;
          2'b10: state_d = BRANCH;
          2'b00: begin
            if (bus.Funct[5]) state_d = EXECI;
`ifdef MC_DECODE_MUL_EN
            else if (bus.MulI) begin
              state_d = MULWAIT;
              cnt_d   = MUL_INIT;
            end
`endif
            else state_d = EXECR;
          end
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR, EXECI: state_d = (is_cmp_s || !known_s) ? FETCH : ALUWB;
`ifdef MC_DECODE_MUL_EN
      MULWAIT: begin
        if (cnt_q == 4'd0) state_d = ALUWB;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // While in reset the outputs decode as FETCH with all writes suppressed
  assign dec_state_s = reset ? state_q : FETCH;

  // Moore output decode
  always_comb begin
    irwrite_s   = 1'b0;
    nextpc_s    = 1'b0;
    regw_s      = 1'b0;
    memw_s      = 1'b0;
    adrsrc_s    = 1'b0;
    resultsrc_s = 2'b00;
    alusrca_s   = 2'b00;
    alusrcb_s   = 2'b00;
    alu_op_s    = 1'b0;
    branch_s    = 1'b0;
    mul_s       = 1'b0;
    case (dec_state_s)
      FETCH: begin
        irwrite_s = reset; nextpc_s = reset;
        alusrca_s = 2'b01; alusrcb_s = 2'b10; resultsrc_s = 2'b10;
      end
      DECODE: begin alusrca_s = 2'b01; alusrcb_s = 2'b10; resultsrc_s = 2'b10; end
      MEMADR: alusrcb_s = 2'b01;
      MEMRD:  adrsrc_s = 1'b1;
      MEMWB:  begin resultsrc_s = 2'b01; regw_s = 1'b1; end
      MEMWR:  begin adrsrc_s = 1'b1; memw_s = 1'b1; end
      EXECR:  alu_op_s = 1'b1;
      EXECI:  begin alusrcb_s = 2'b01; alu_op_s = 1'b1; end
      ALUWB:  regw_s = 1'b1;
      BRANCH: begin
        alusrca_s = 2'b10; alusrcb_s = 2'b01; resultsrc_s = 2'b10; branch_s = 1'b1;
      end
`ifdef MC_DECODE_MUL_EN
      MULWAIT: mul_s = 1'b1;
`endif
      default: begin
        irwrite_s = 1'b0;
      end
    endcase
  end

  // ALU control and flag-write enables; unknown commands write nothing
  always_comb begin
    aluctrl_s = 3'd0;
    flagw_s   = 2'b00;
    if (mul_s) begin
      aluctrl_s = 3'd6;
      flagw_s   = {bus.Funct[0], 1'b0};
    end else if (alu_op_s) begin
      aluctrl_s  = alu_code_s;
      flagw_s[1] = known_s & (bus.Funct[0] | is_cmp_s);
      flagw_s[0] = known_s & (bus.Funct[0] | is_cmp_s) & arith_s;
    end else begin
      aluctrl_s = 3'd0;
    end
  end

  assign bus.IRWrite    = irwrite_s;
  assign bus.NextPC     = nextpc_s;
  assign bus.RegW       = regw_s;
  assign bus.MemW       = memw_s;
  assign bus.AdrSrc     = adrsrc_s;
  assign bus.ResultSrc  = resultsrc_s;
  assign bus.ALUSrcA    = alusrca_s;
  assign bus.ALUSrcB    = alusrcb_s;
  assign bus.FlagW      = flagw_s;
  assign bus.ALUControl = ALUCTRL_W'(aluctrl_s);
  assign bus.PCS        = ((bus.Rd == 4'hF) & regw_s) | branch_s;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
  assign bus.State      = state_q;

endmodule
